// File: rtl/system_memory_scanout.sv
// Frame-buffer scanout reader: streams one frame of 32-bit words from
// memory port 2 through a word FIFO and emits them as 8-bit pixels.
//
// Build option: define SCANOUT_BIG_ENDIAN_EN to emit bits[31:24] as the
// first pixel of each word. The default emits bits[7:0] first.
//
// Parameters:
//   BASE_WORD    first word address of the frame
//   FRAME_WORDS  words per frame
//   FIFO_DEPTH   word FIFO entries (power of 2, >= 2)
//
// Ports:
//   clk, reset      single clock, synchronous active-high reset
//   enable          level request to scan frames
//   mem_*           read-only memory port; readdata valid 1 clk after chipselect
//   out_data/valid/ready/sop/eop   pixel stream with frame marks
//   frame_done      pulse when the eop pixel is accepted
//   busy            high whenever the scanner is not idle

module system_memory_scanout #(
   parameter int BASE_WORD   = 0,
   parameter int FRAME_WORDS = 19200,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   output logic [16:0] mem_address,
   output logic        mem_chipselect,
   output logic [3:0]  mem_byteenable,
   input  logic [31:0] mem_readdata,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_sop,
   output logic        out_eop,
   output logic        frame_done,
   output logic        busy
);

   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int CW  = AW + 1;
   localparam int WCW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

   localparam logic [16:0]    BASE_ADDR = 17'(BASE_WORD);
   localparam logic [WCW-1:0] LAST_WORD = WCW'(FRAME_WORDS - 1);
   localparam logic [CW:0]    DEPTH_C   = (CW + 1)'(FIFO_DEPTH);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   logic [1:0]     state_q, state_d;
   logic [16:0]    addr_q, addr_d;
   logic [WCW-1:0] word_cnt_q, word_cnt_d;
   logic           inflight_q, inflight_d;

   logic [31:0]    fifo_mem_q [FIFO_DEPTH];
   logic [31:0]    fifo_mem_d [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  count_q, count_d;

   logic [1:0]     pix_idx_q, pix_idx_d;
   logic [WCW-1:0] out_word_q, out_word_d;

   logic           issue;
   logic           push;
   logic           pop;
   logic           valid;
   logic           accept;
   logic           last_px;
   logic           is_eop;
   logic           is_sop;
   logic           done;
   logic [31:0]    head;
   logic [1:0]     byte_sel;

   // A read may only be issued when its data is guaranteed a FIFO slot,
   // counting the word still on its way back from memory.
   assign issue = (state_q == ST_FETCH) &&
                  (({1'b0, count_q} + {{CW{1'b0}}, inflight_q}) < DEPTH_C);

   assign push    = inflight_q;
   assign head    = fifo_mem_q[rd_ptr_q];

   // The FIFO head word is the unpacker's working word; it is popped when
   // its last pixel is taken, so the next word is presented with no bubble.
   assign valid   = (count_q != '0);
   assign accept  = valid && out_ready;
   assign last_px = (pix_idx_q == 2'd3);
   assign pop     = accept && last_px;
   assign is_sop  = valid && (pix_idx_q == 2'd0) && (out_word_q == '0);
   assign is_eop  = valid && last_px && (out_word_q == LAST_WORD);
   assign done    = accept && is_eop;

`ifdef SCANOUT_BIG_ENDIAN_EN
   assign byte_sel = ~pix_idx_q;
`else
   assign byte_sel = pix_idx_q;
`endif

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      word_cnt_d = word_cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            addr_d     = BASE_ADDR;
            word_cnt_d = '0;
            if (enable) begin
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (issue) begin
               addr_d = addr_q + 17'd1;
               if (word_cnt_q == LAST_WORD) begin
                  state_d = ST_DRAIN;
               end else begin
                  word_cnt_d = word_cnt_q + WCW'(1);
               end
            end
         end
         ST_DRAIN: begin
            if (done) begin
               state_d = ST_IDLE;
               addr_d  = BASE_ADDR;
            end
         end
         default: begin
            state_d = ST_IDLE;
            addr_d  = BASE_ADDR;
         end
      endcase
   end

   assign inflight_d = issue;

   always_comb begin
      fifo_mem_d = fifo_mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      if (push) begin
         fifo_mem_d[wr_ptr_q] = mem_readdata;
         wr_ptr_d             = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      pix_idx_d  = pix_idx_q;
      out_word_d = out_word_q;
      if (accept) begin
         pix_idx_d = pix_idx_q + 2'd1;
      end
      if (pop) begin
         if (out_word_q == LAST_WORD) begin
            out_word_d = '0;
         end else begin
            out_word_d = out_word_q + WCW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         addr_q     <= BASE_ADDR;
         word_cnt_q <= '0;
         inflight_q <= 1'b0;
         fifo_mem_q <= '{default: '0};
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         pix_idx_q  <= '0;
         out_word_q <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         word_cnt_q <= word_cnt_d;
         inflight_q <= inflight_d;
         fifo_mem_q <= fifo_mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         pix_idx_q  <= pix_idx_d;
         out_word_q <= out_word_d;
      end
   end

   assign mem_address    = addr_q;
   assign mem_chipselect = issue;
   assign mem_byteenable = 4'hF;
   assign out_data       = head[{byte_sel, 3'b000} +: 8];
   assign out_valid      = valid;
   assign out_sop        = is_sop;
   assign out_eop        = is_eop;
   assign frame_done     = done;
   assign busy           = (state_q != ST_IDLE);

endmodule
